// File: rtl/video_pkg.sv
// Shared constants, types and helpers for the RGB565 -> YCbCr 4:2:2 video path.
// BT.601 coefficients, clamp limits and the default blanking word live here.
package video_pkg;

  localparam logic [15:0] BLANK_WORD_DEFAULT = 16'h1080;

  localparam logic signed [17:0] K_YR = 18'sd66;
  localparam logic signed [17:0] K_YG = 18'sd129;
  localparam logic signed [17:0] K_YB = 18'sd25;
  localparam logic signed [17:0] K_BR = -18'sd38;
  localparam logic signed [17:0] K_BG = -18'sd74;
  localparam logic signed [17:0] K_BB = 18'sd112;
  localparam logic signed [17:0] K_RR = 18'sd112;
  localparam logic signed [17:0] K_RG = -18'sd94;
  localparam logic signed [17:0] K_RB = -18'sd18;
  localparam logic signed [17:0] K_ROUND = 18'sd128;

  localparam logic signed [10:0] Y_OFS = 11'sd16;
  localparam logic signed [10:0] C_OFS = 11'sd128;
  localparam logic [7:0] Y_MIN = 8'd16;
  localparam logic [7:0] Y_MAX = 8'd235;
  localparam logic [7:0] C_MIN = 8'd16;
  localparam logic [7:0] C_MAX = 8'd240;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic logic [7:0] clamp_u8(input logic signed [10:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic signed [10:0] lo_s;
    logic signed [10:0] hi_s;
    lo_s = signed'({3'b000, lo});
    hi_s = signed'({3'b000, hi});
    if (v < lo_s)      clamp_u8 = lo;
    else if (v > hi_s) clamp_u8 = hi;
    else               clamp_u8 = 8'(v);
  endfunction

endpackage

// File: rtl/rgb_to_ycbcr444.sv
// RGB565 -> clamped BT.601 YCbCr 4:4:4, three register stages (expand, multiply, offset/clamp).
// Free-running stream with no backpressure; de/hsync/vsync ride along with the pixel.
module rgb_to_ycbcr444 (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic [15:0] rgb,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  output logic [7:0]  y_o,
  output logic [7:0]  cb_o,
  output logic [7:0]  cr_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o
);
  import video_pkg::*;

  logic [7:0]        r8_d, r8_q, g8_d, g8_q, b8_d, b8_q;
  logic signed [9:0] y2_d, y2_q, cb2_d, cb2_q, cr2_d, cr2_q;
  logic [7:0]        y3_d, y3_q, cb3_d, cb3_q, cr3_d, cr3_q;
  logic [2:0]        ctl1_d, ctl1_q, ctl2_d, ctl2_q, ctl3_d, ctl3_q;

  rgb565_t           px;
  logic signed [17:0] rs, gs, bs;
  logic signed [17:0] y_acc, cb_acc, cr_acc;

  always_comb begin
    px     = rgb565_t'(rgb);
    // Replicate MSBs so full-scale 5/6-bit codes map to 255.
    r8_d   = {px.r, px.r[4:2]};
    g8_d   = {px.g, px.g[5:4]};
    b8_d   = {px.b, px.b[4:2]};
    ctl1_d = {de, hsync, vsync};

    rs     = signed'({10'd0, r8_q});
    gs     = signed'({10'd0, g8_q});
    bs     = signed'({10'd0, b8_q});
    y_acc  = K_YR * rs + K_YG * gs + K_YB * bs + K_ROUND;
    cb_acc = K_BR * rs + K_BG * gs + K_BB * bs + K_ROUND;
    cr_acc = K_RR * rs + K_RG * gs + K_RB * bs + K_ROUND;
    y2_d   = 10'(y_acc >>> 8);
    cb2_d  = 10'(cb_acc >>> 8);
    cr2_d  = 10'(cr_acc >>> 8);
    ctl2_d = ctl1_q;

    y3_d   = clamp_u8(11'(y2_q) + Y_OFS, Y_MIN, Y_MAX);
    cb3_d  = clamp_u8(11'(cb2_q) + C_OFS, C_MIN, C_MAX);
    cr3_d  = clamp_u8(11'(cr2_q) + C_OFS, C_MIN, C_MAX);
    ctl3_d = ctl2_q;
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r8_q   <= '0;
      g8_q   <= '0;
      b8_q   <= '0;
      y2_q   <= '0;
      cb2_q  <= '0;
      cr2_q  <= '0;
      y3_q   <= '0;
      cb3_q  <= '0;
      cr3_q  <= '0;
      ctl1_q <= '0;
      ctl2_q <= '0;
      ctl3_q <= '0;
    end else begin
      r8_q   <= r8_d;
      g8_q   <= g8_d;
      b8_q   <= b8_d;
      y2_q   <= y2_d;
      cb2_q  <= cb2_d;
      cr2_q  <= cr2_d;
      y3_q   <= y3_d;
      cb3_q  <= cb3_d;
      cr3_q  <= cr3_d;
      ctl1_q <= ctl1_d;
      ctl2_q <= ctl2_d;
      ctl3_q <= ctl3_d;
    end
  end

  assign y_o     = y3_q;
  assign cb_o    = cb3_q;
  assign cr_o    = cr3_q;
  assign de_o    = ctl3_q[2];
  assign hsync_o = ctl3_q[1];
  assign vsync_o = ctl3_q[0];

endmodule

// File: rtl/ycbcr422_formatter.sv
// RGB565 -> 16-bit YCbCr 4:2:2 HDMI word stream, fixed 4-cycle latency, never stalls.
// Define CHROMA_AVG_EN to average each chroma sample with the previous pixel's instead of decimating.
module ycbcr422_formatter #(
  parameter logic [15:0] BLANK_WORD = video_pkg::BLANK_WORD_DEFAULT
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic [15:0] pix_rgb,
  input  logic        pix_de,
  input  logic        pix_hsync,
  input  logic        pix_vsync,
  output logic [15:0] hdmi_d,
  output logic        hdmi_de,
  output logic        hdmi_hsync,
  output logic        hdmi_vsync
);
  import video_pkg::*;

  logic [7:0] y3, cb3, cr3;
  logic       de3, hs3, vs3;

  rgb_to_ycbcr444 u_csc (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .rgb       (pix_rgb),
    .de        (pix_de),
    .hsync     (pix_hsync),
    .vsync     (pix_vsync),
    .y_o       (y3),
    .cb_o      (cb3),
    .cr_o      (cr3),
    .de_o      (de3),
    .hsync_o   (hs3),
    .vsync_o   (vs3)
  );

  logic [15:0] hdmi_d_d, hdmi_d_q;
  logic        hdmi_de_d, hdmi_de_q;
  logic        hdmi_hs_d, hdmi_hs_q;
  logic        hdmi_vs_d, hdmi_vs_q;
  logic        phase_d, phase_q;
  logic [7:0]  c_sel, c_out;
`ifdef CHROMA_AVG_EN
  logic        de_prev_d, de_prev_q;
  logic [7:0]  cb_prev_d, cb_prev_q, cr_prev_d, cr_prev_q;
  logic [7:0]  c_prev;
  logic [8:0]  c_sum;
`endif

  always_comb begin
    // phase_q is already 0 on the first DE cycle of a run, since any non-DE cycle clears it.
    c_sel     = phase_q ? cr3 : cb3;
`ifdef CHROMA_AVG_EN
    c_prev    = de_prev_q ? (phase_q ? cr_prev_q : cb_prev_q) : c_sel;
    c_sum     = ({1'b0, c_sel} + {1'b0, c_prev} + 9'd1) >> 1;
    c_out     = 8'(c_sum);
    de_prev_d = de3;
    cb_prev_d = cb3;
    cr_prev_d = cr3;
`else
    c_out     = c_sel;
`endif
    phase_d   = de3 ? ~phase_q : 1'b0;
    hdmi_d_d  = de3 ? {y3, c_out} : BLANK_WORD;
    hdmi_de_d = de3;
    hdmi_hs_d = hs3;
    hdmi_vs_d = vs3;
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      hdmi_d_q  <= BLANK_WORD;
      hdmi_de_q <= 1'b0;
      hdmi_hs_q <= 1'b0;
      hdmi_vs_q <= 1'b0;
      phase_q   <= 1'b0;
`ifdef CHROMA_AVG_EN
      de_prev_q <= 1'b0;
      cb_prev_q <= '0;
      cr_prev_q <= '0;
`endif
    end else begin
      hdmi_d_q  <= hdmi_d_d;
      hdmi_de_q <= hdmi_de_d;
      hdmi_hs_q <= hdmi_hs_d;
      hdmi_vs_q <= hdmi_vs_d;
      phase_q   <= phase_d;
`ifdef CHROMA_AVG_EN
      de_prev_q <= de_prev_d;
      cb_prev_q <= cb_prev_d;
      cr_prev_q <= cr_prev_d;
`endif
    end
  end

  assign hdmi_d     = hdmi_d_q;
  assign hdmi_de    = hdmi_de_q;
  assign hdmi_hsync = hdmi_hs_q;
  assign hdmi_vsync = hdmi_vs_q;

endmodule

// File: tb/tb_ycbcr422_formatter.sv
// Bench for ycbcr422_formatter: directed and random pixels against a per-pixel reference model.
// Honours CHROMA_AVG_EN the same way as the design.
module tb_ycbcr422_formatter;

  localparam logic [15:0] BLANK = 16'h1080;

  logic        clk_25mhz = 1'b0;
  logic        rst_n;
  logic [15:0] pix_rgb;
  logic        pix_de, pix_hsync, pix_vsync;
  logic [15:0] hdmi_d;
  logic        hdmi_de, hdmi_hsync, hdmi_vsync;

  always #20 clk_25mhz = ~clk_25mhz;

  ycbcr422_formatter #(.BLANK_WORD(BLANK)) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .pix_rgb    (pix_rgb),
    .pix_de     (pix_de),
    .pix_hsync  (pix_hsync),
    .pix_vsync  (pix_vsync),
    .hdmi_d     (hdmi_d),
    .hdmi_de    (hdmi_de),
    .hdmi_hsync (hdmi_hsync),
    .hdmi_vsync (hdmi_vsync)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        de;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   run_pos  = 0;
  bit   m_prev_de = 1'b0;
  int   m_prev_cb = 0;
  int   m_prev_cr = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Returns {Y, Cb, Cr} for one RGB565 pixel.
  function automatic logic [23:0] ref_ycc(input logic [15:0] p);
    int r5, g6, b5, r, g, b, y, cb, cr;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r  = r5 * 8 + r5 / 4;
    g  = g6 * 4 + g6 / 16;
    b  = b5 * 8 + b5 / 4;
    y  = (66 * r + 129 * g + 25 * b + 128) >>> 8;
    cb = (-38 * r - 74 * g + 112 * b + 128) >>> 8;
    cr = (112 * r - 94 * g - 18 * b + 128) >>> 8;
    y  = clip(y + 16, 16, 235);
    cb = clip(cb + 128, 16, 240);
    cr = clip(cr + 128, 16, 240);
    return {8'(y), 8'(cb), 8'(cr)};
  endfunction

  task automatic model_reset();
    exp_t b;
    b.d = BLANK; b.de = 1'b0; b.hs = 1'b0; b.vs = 1'b0;
    exp_q.delete();
    repeat (3) exp_q.push_back(b);
    m_prev_de = 1'b0;
    run_pos   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d"}, hdmi_d, BLANK);
    check({tag, "_ctl"}, {13'd0, hdmi_de, hdmi_hsync, hdmi_vsync}, 16'd0);
  endtask

  task automatic step(input logic [15:0] p, input logic de, input logic hs, input logic vs);
    exp_t        e;
    logic [23:0] ycc;
    int          sel, c;
`ifdef CHROMA_AVG_EN
    int          prv;
`endif
    pix_rgb = p; pix_de = de; pix_hsync = hs; pix_vsync = vs;
    ycc = ref_ycc(p);
    if (de) begin
      run_pos = m_prev_de ? run_pos + 1 : 0;
      sel = (run_pos % 2 == 1) ? int'(ycc[7:0]) : int'(ycc[15:8]);
`ifdef CHROMA_AVG_EN
      prv = (run_pos % 2 == 1) ? m_prev_cr : m_prev_cb;
      c   = (run_pos == 0) ? sel : (sel + prv + 1) / 2;
`else
      c   = sel;
`endif
      e.d = {ycc[23:16], 8'(c)};
    end else begin
      e.d = BLANK;
    end
    e.de = de; e.hs = hs; e.vs = vs;
    m_prev_de = de;
    m_prev_cb = int'(ycc[15:8]);
    m_prev_cr = int'(ycc[7:0]);
    exp_q.push_back(e);
    @(posedge clk_25mhz); #1;
    e = exp_q.pop_front();
    check("hdmi_d", hdmi_d, e.d);
    check("hdmi_ctl", {13'd0, hdmi_de, hdmi_hsync, hdmi_vsync}, {13'd0, e.de, e.hs, e.vs});
  endtask

  task automatic idle(input int n);
    repeat (n) step(16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    pix_rgb = '0; pix_de = 1'b0; pix_hsync = 1'b0; pix_vsync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_25mhz);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(4);

    // Black, white and saturated red runs
    repeat (8) step(16'h0000, 1'b1, 1'b0, 1'b0);
    idle(4);
    repeat (6) step(16'hFFFF, 1'b1, 1'b0, 1'b0);
    idle(4);
    repeat (4) step(16'hF800, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Runs of 3 and 5 split by one blank cycle, with sync pulses
    step(16'h0000, 1'b0, 1'b1, 1'b1);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (3) step(16'($urandom), 1'b1, 1'b0, 1'b0);
    step(16'h1234, 1'b0, 1'b0, 1'b1);
    repeat (5) step(16'($urandom), 1'b1, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Asynchronous reset in the middle of a run
    repeat (3) step(16'($urandom), 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk_25mhz);
    #1;
    check_reset_outputs("held_reset");
    model_reset();
    rst_n = 1'b1;
    repeat (6) step(16'($urandom), 1'b1, 1'b1, 1'b0);
    idle(4);

    // Red then blue pair exercises the chroma select/average path
    step(16'hF800, 1'b1, 1'b0, 1'b0);
    step(16'h001F, 1'b1, 1'b0, 1'b0);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      step(16'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ycbcr422_formatter.md
YCBCR422_FORMATTER -- requirements
Module: ycbcr422_formatter

Interface
REQ-001 SHALL have parameter BLANK_WORD, default 16'h1080, which is the hdmi_d value driven outside active video (Y=0x10, C=0x80).
REQ-002 SHALL have port clk_25mhz, input, 1 bit: pixel clock, rising-edge; this is the only clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port pix_rgb, input, 16 bits: RGB565 pixel, {R[4:0],G[5:0],B[4:0]}, sampled every cycle.
REQ-005 SHALL have port pix_de, input, 1 bit: active-video flag aligned with pix_rgb.
REQ-006 SHALL have port pix_hsync, input, 1 bit, and port pix_vsync, input, 1 bit: syncs aligned with pix_rgb; polarity is passed through unchanged.
REQ-007 SHALL have port hdmi_d, output, 16 bits: {Y[7:0], C[7:0]} 4:2:2 word.
REQ-008 SHALL have ports hdmi_de, hdmi_hsync and hdmi_vsync, output, 1 bit each: delayed copies of pix_de, pix_hsync and pix_vsync.

Function
REQ-009 SHALL stream with no handshake: one input accepted per cycle, one output produced per cycle, never stalls.
REQ-010 SHALL have fixed latency of 4 cycles from input to hdmi_d/hdmi_de/hdmi_hsync/hdmi_vsync; all four outputs stay mutually aligned.
REQ-011 Stage 1 SHALL expand to 8 bits by bit replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-012 Stage 2 SHALL form BT.601 products with signed 18-bit accumulation:
- Y=(66R+129G+25B+128)>>>8
- Cb=(-38R-74G+112B+128)>>>8
- Cr=(112R-94G-18B+128)>>>8
REQ-013 Stage 3 SHALL add offsets (Y+16, Cb+128, Cr+128) and clamp Y to [16,235] and Cb/Cr to [16,240].
REQ-014 Stage 4 SHALL hold a 1-bit chroma phase that is 0 on the first DE cycle of each run and toggles every DE cycle; phase 0 outputs Cb, phase 1 outputs Cr.
REQ-015 An odd-length DE run SHALL end on a Cb word; the next run restarts at phase 0 regardless.
REQ-016 When the delayed DE is 0, hdmi_d SHALL equal BLANK_WORD; syncs still propagate.
REQ-017 A DE deasserted for a single cycle SHALL reset the phase, and the next DE cycle is treated as a new run.

Reset
REQ-018 While rst_n=0, SHALL force hdmi_d=BLANK_WORD, hdmi_de=0, hdmi_hsync=0, hdmi_vsync=0, clear all pipeline valid/DE/sync bits, and set phase=0.
REQ-019 Reset asserted mid-line SHALL take effect immediately; the first 4 cycles after release output blank with syncs 0, then track the input.

Configuration
REQ-020 With CHROMA_AVG_EN defined, the output chroma SHALL be (C(n)+C(n-1)+1)>>1 for the selected component, where C(n-1)=C(n) on the first pixel of a run; latency stays 4 cycles.
REQ-021 Without CHROMA_AVG_EN, the output chroma SHALL be the selected component of pixel n only (pure decimation).

Structure
REQ-022 Package video_pkg SHALL hold:
- the coefficient localparams
- the clamp limits
- the BLANK_WORD default
- a packed rgb565_t struct
REQ-023 Stages 1-3 SHALL be implemented in sub-module rgb_to_ycbcr444 (3-cycle latency); stage 4 (phase, chroma select/average, blanking mux) SHALL live in ycbcr422_formatter.

Verification
REQ-024 Verification SHALL cover:
- Constant 16'h0000 with DE=1 for 8 cycles -> hdmi_d=16'h1080 on every DE output cycle.
- Constant 16'hFFFF with DE=1 -> Y=0xEB; C alternates 0x80/0x80; first DE output at cycle 4 after first input.
- Red 16'hF800, DE run of 4 -> hdmi_d sequence 16'h525A, 16'h52F0, 16'h525A, 16'h52F0.
- hsync/vsync pulses and DE toggling with DE runs of 3 and 5 separated by 1 blank cycle -> syncs delayed exactly 4 cycles; phase restarts at Cb for each run; blank cycle outputs 16'h1080.
- rst_n pulsed low mid-run -> outputs reach reset values within the same cycle (asynchronous); first valid output 4 cycles after release with phase 0.
- CHROMA_AVG_EN: red then blue (16'h001F) pixel pair -> second word C=(Cr_red 240 + Cr_blue 110 +1)>>1=175 (0xAF); without the macro the second word C=0x6E.
